// File: rtl/alert_pkg.sv
`default_nettype none
// ============================================================================
//  Module : alert_pkg
//  Brief  : Shared types, widths and helpers for the alert scheduler slice.
//  Rev    : 1.0  initial release
// ============================================================================
package alert_pkg;

    localparam int ID_W   = 2;
    localparam int MAX_CH = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BEEP_ON  = 2'd1,
        BEEP_OFF = 2'd2,
        HOLDOFF  = 2'd3
    } state_e;

    function automatic logic [MAX_CH-1:0] onehot(input logic [ID_W-1:0] id);
        return MAX_CH'(1) << id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alert_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module : alert_scheduler_if
//  Brief  : Request / beeper-drive bundle between validation logic and speaker.
//  Rev    : 1.0  initial release
// ============================================================================
interface alert_scheduler_if #(
    parameter int N_CH = 3
) ();

    logic                       ena;
    logic [N_CH-1:0]            req;
    logic                       spk_out;
    logic [N_CH-1:0]            spk_sel;
    logic [alert_pkg::ID_W-1:0] grant_id;
    logic                       busy;

    modport master (
        output ena,
        output req,
        input  spk_out,
        input  spk_sel,
        input  grant_id,
        input  busy
    );

    modport slave (
        input  ena,
        input  req,
        output spk_out,
        output spk_sel,
        output grant_id,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/alert_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : alert_rr_arbiter
//  Brief  : Combinational direction pick plus round-robin pointer register.
//           ALERT_FIXED_PRIO_EN selects lowest-index-wins with no pointer.
//  Rev    : 1.0  initial release
// ============================================================================
module alert_rr_arbiter
    import alert_pkg::*;
#(
    parameter int N_CH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  i_req,
    input  logic             i_take,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_grant
);

`ifdef ALERT_FIXED_PRIO_EN

    logic w_unused_ok;
    assign w_unused_ok = ^{clk, rst, i_take};

    always_comb begin
        o_valid = |i_req;
        o_grant = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_grant = ID_W'(k);
            end
        end
    end

`else

    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W:0]   w_cand;
    logic            w_found;

    // Search upward from the pointer, folding the index back below N_CH.
    always_comb begin
        o_valid = |i_req;
        o_grant = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(N_CH)) begin
                w_cand = w_cand - (ID_W+1)'(N_CH);
            end
            if (!w_found && i_req[w_cand[ID_W-1:0]]) begin
                w_found = 1'b1;
                o_grant = w_cand[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (i_take) begin
            r_rr_ptr <= (o_grant == ID_W'(N_CH - 1)) ? '0 : o_grant + ID_W'(1);
        end
    end

`endif

endmodule
`default_nettype wire

// File: rtl/alert_scheduler.sv
`default_nettype none
// ============================================================================
//  Module : alert_scheduler
//  Brief  : Shares one beeper between N_CH direction requests; each grant plays
//           (id+1) beeps then a silent holdoff. Arbitration mode is selected
//           by ALERT_FIXED_PRIO_EN (see alert_rr_arbiter).
//  Rev    : 1.0  initial release
// ============================================================================
module alert_scheduler
    import alert_pkg::*;
#(
    parameter int N_CH           = 3,
    parameter int BEEP_CYCLES    = 1000,
    parameter int GAP_CYCLES     = 1000,
    parameter int HOLDOFF_CYCLES = 4000,
    parameter int CNT_W          = 27
) (
    input  logic              clk,
    input  logic              rst,
    alert_scheduler_if.slave  bus
);

    localparam logic [1:0] c_IDLE     = IDLE;
    localparam logic [1:0] c_BEEP_ON  = BEEP_ON;
    localparam logic [1:0] c_BEEP_OFF = BEEP_OFF;
    localparam logic [1:0] c_HOLDOFF  = HOLDOFF;

    localparam logic [CNT_W-1:0] c_BEEP_LOAD = CNT_W'(BEEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_timer;
    logic [ID_W-1:0]   r_beep_cnt;
    logic              r_spk_out;
    logic [N_CH-1:0]   r_spk_sel;
    logic [ID_W-1:0]   r_grant_id;
    logic              r_busy;

    logic              w_valid;
    logic [ID_W-1:0]   w_grant;
    logic              w_take;
    logic [MAX_CH-1:0] w_onehot;

    assign w_take   = (r_state == c_IDLE) && bus.ena && w_valid;
    assign w_onehot = onehot(w_grant);

    alert_rr_arbiter #(
        .N_CH    (N_CH)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (bus.req),
        .i_take  (w_take),
        .o_valid (w_valid),
        .o_grant (w_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_timer    <= '0;
            r_beep_cnt <= '0;
            r_spk_out  <= 1'b0;
            r_spk_sel  <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
        end else if (!bus.ena) begin
            // Disabling abandons any burst outright; the arbiter pointer is kept.
            r_state    <= c_IDLE;
            r_timer    <= '0;
            r_beep_cnt <= '0;
            r_spk_out  <= 1'b0;
            r_spk_sel  <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_valid) begin
                        r_state    <= c_BEEP_ON;
                        r_timer    <= c_BEEP_LOAD;
                        r_beep_cnt <= w_grant;
                        r_spk_out  <= 1'b1;
                        r_spk_sel  <= w_onehot[N_CH-1:0];
                        r_grant_id <= w_grant;
                        r_busy     <= 1'b1;
                    end
                end
                c_BEEP_ON: begin
                    if (r_timer == '0) begin
                        r_state   <= c_BEEP_OFF;
                        r_timer   <= c_GAP_LOAD;
                        r_spk_out <= 1'b0;
                    end else begin
                        r_timer <= r_timer - CNT_W'(1);
                    end
                end
                c_BEEP_OFF: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - CNT_W'(1);
                    end else if (r_beep_cnt != '0) begin
                        r_state    <= c_BEEP_ON;
                        r_timer    <= c_BEEP_LOAD;
                        r_beep_cnt <= r_beep_cnt - ID_W'(1);
                        r_spk_out  <= 1'b1;
                    end else begin
                        r_state   <= c_HOLDOFF;
                        r_timer   <= c_HOLD_LOAD;
                        r_spk_sel <= '0;
                    end
                end
                c_HOLDOFF: begin
                    if (r_timer == '0) begin
                        r_state    <= c_IDLE;
                        r_busy     <= 1'b0;
                        r_grant_id <= '0;
                    end else begin
                        r_timer <= r_timer - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.spk_out  = r_spk_out;
    assign bus.spk_sel  = r_spk_sel;
    assign bus.grant_id = r_grant_id;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alert_scheduler.sv
`default_nettype none
// ============================================================================
//  Module : tb_alert_scheduler
//  Brief  : Directed self-checking bench for alert_scheduler (BEEP=4, GAP=3,
//           HOLDOFF=10). Expectations follow ALERT_FIXED_PRIO_EN when defined.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_alert_scheduler;

    localparam int N_CH = 3;
    localparam int BEEP = 4;
    localparam int GAP  = 3;
    localparam int HOLD = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alert_scheduler_if #(.N_CH(N_CH)) bus_if ();

    alert_scheduler #(
        .N_CH           (N_CH),
        .BEEP_CYCLES    (BEEP),
        .GAP_CYCLES     (GAP),
        .HOLDOFF_CYCLES (HOLD),
        .CNT_W          (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_spk"},  32'(bus_if.spk_out),  32'd0);
        chk({tag, "_sel"},  32'(bus_if.spk_sel),  32'd0);
        chk({tag, "_gid"},  32'(bus_if.grant_id), 32'd0);
        chk({tag, "_busy"}, 32'(bus_if.busy),     32'd0);
    endtask

    initial begin
        int exp_g [4];
        int got_g [4];
        int ng;
        logic prev_busy;
        int exp_after_idle;

`ifdef ALERT_FIXED_PRIO_EN
        exp_g          = '{0, 0, 0, 0};
        exp_after_idle = 0;
`else
        exp_g          = '{0, 1, 2, 0};
        exp_after_idle = 2;
`endif

        bus_if.ena = 1'b0;
        bus_if.req = '0;
        #2;
        chk_idle("reset");
        tick();
        tick();
        rst = 1'b0;

        // ena low in IDLE: requests are ignored
        bus_if.req = 3'b111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ena0_busy", 32'(bus_if.busy), 32'd0);
        end

        // Single held request on direction 0: 4 on, 3 off, 10 holdoff, idle, regrant
        bus_if.req = 3'b001;
        bus_if.ena = 1'b1;
        tick();
        chk("t2_spk0", 32'(bus_if.spk_out),  32'd1);
        chk("t2_sel0", 32'(bus_if.spk_sel),  32'd1);
        chk("t2_gid0", 32'(bus_if.grant_id), 32'd0);
        chk("t2_busy0", 32'(bus_if.busy),    32'd1);
        for (int c = 1; c <= 18; c++) begin
            tick();
            chk("t2_spk",  32'(bus_if.spk_out), ((c < 4) || (c == 18)) ? 32'd1 : 32'd0);
            chk("t2_busy", 32'(bus_if.busy),    (c != 17) ? 32'd1 : 32'd0);
            chk("t2_sel",  32'(bus_if.spk_sel), ((c < 7) || (c == 18)) ? 32'd1 : 32'd0);
        end
        bus_if.ena = 1'b0;
        bus_if.req = '0;
        tick();
        chk_idle("t2_abort");

        // One-cycle request on direction 2: full 3-beep burst still completes
        bus_if.ena = 1'b1;
        bus_if.req = 3'b100;
        tick();
        bus_if.req = '0;
        chk("t3_gid0", 32'(bus_if.grant_id), 32'd2);
        chk("t3_sel0", 32'(bus_if.spk_sel),  32'd4);
        chk("t3_spk0", 32'(bus_if.spk_out),  32'd1);
        for (int c = 1; c <= 31; c++) begin
            tick();
            chk("t3_spk",  32'(bus_if.spk_out), ((c < 21) && ((c % 7) < 4)) ? 32'd1 : 32'd0);
            chk("t3_busy", 32'(bus_if.busy),    (c < 31) ? 32'd1 : 32'd0);
            chk("t3_sel",  32'(bus_if.spk_sel), (c < 21) ? 32'd4 : 32'd0);
        end

        // All directions held: record the first four grants
        bus_if.req = 3'b111;
        ng         = 0;
        prev_busy  = 1'b0;
        for (int i = 0; i < 300 && ng < 4; i++) begin
            tick();
            if (!prev_busy && bus_if.busy) begin
                got_g[ng] = int'(bus_if.grant_id);
                ng++;
            end
            prev_busy = bus_if.busy;
        end
        chk("t4_count", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) chk("t4_order", 32'(got_g[i]), 32'(exp_g[i]));
        end
        bus_if.ena = 1'b0;
        bus_if.req = '0;
        tick();
        chk_idle("t4_abort");

        // ena dropped during the second beep of a direction-1 burst
        bus_if.ena = 1'b1;
        bus_if.req = 3'b010;
        tick();
        chk("t5_gid", 32'(bus_if.grant_id), 32'd1);
        for (int c = 1; c <= 8; c++) tick();
        chk("t5_beep2", 32'(bus_if.spk_out), 32'd1);
        bus_if.ena = 1'b0;
        tick();
        chk_idle("t5_drop");
        bus_if.ena = 1'b1;
        tick();
        chk("t5_regrant_spk", 32'(bus_if.spk_out),  32'd1);
        chk("t5_regrant_gid", 32'(bus_if.grant_id), 32'd1);
        chk("t5_regrant_sel", 32'(bus_if.spk_sel),  32'd2);
        bus_if.ena = 1'b0;
        bus_if.req = '0;
        tick();

        // No requests for 100 cycles, then the pointer must still be where it was
        bus_if.ena = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("t6_quiet", 32'({bus_if.busy, bus_if.spk_out, bus_if.spk_sel}), 32'd0);
        end
        bus_if.req = 3'b111;
        tick();
        chk("t6_ptr_gid", 32'(bus_if.grant_id), 32'(exp_after_idle));

        // Asynchronous reset mid-burst clears outputs before the next edge
        tick();
        tick();
        chk("t1_pre_spk", 32'(bus_if.spk_out), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk_idle("t1_async");
        tick();
        rst = 1'b0;
        tick();
        chk("t1_post_gid", 32'(bus_if.grant_id), 32'd0);
        chk("t1_post_spk", 32'(bus_if.spk_out),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
